// File: rtl/irda_sip_sched_if.sv
// Bundle of control, status and generator handshake signals for the SIP scheduler.
// master = register file / generator side, slave = the scheduler itself.
interface irda_sip_sched_if #(
  parameter int CNT_W = 24
);
  logic             fast_enable;
  logic             sip_en_i;
  logic [CNT_W-1:0] sip_period_i;
  logic             sw_sip_req_i;
  logic             tx_busy_i;
  logic             sip_end_i;
  logic             err_clr_i;
  logic             sip_o;
  logic             sip_busy_o;
  logic             sip_done_o;
  logic             sip_timeout_o;

  modport master (
    output fast_enable, sip_en_i, sip_period_i, sw_sip_req_i, tx_busy_i, sip_end_i, err_clr_i,
    input  sip_o, sip_busy_o, sip_done_o, sip_timeout_o
  );

  modport slave (
    input  fast_enable, sip_en_i, sip_period_i, sw_sip_req_i, tx_busy_i, sip_end_i, err_clr_i,
    output sip_o, sip_busy_o, sip_done_o, sip_timeout_o
  );
endinterface

// File: rtl/irda_sip_sched.sv
// IrDA fast-mode SIP scheduler: merges a periodic timer and software requests,
// defers them while a frame is on the air, and runs the request / end-of-SIP
// handshake with the pulse generator, flagging completion or timeout.
module irda_sip_sched #(
  parameter int CNT_W     = 24,
  parameter int TO_CYCLES = 511
) (
  input  logic              clk,
  input  logic              wb_rst_n,
  irda_sip_sched_if.slave   sif
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_END, WAIT_IDLE} state_t;

  // Last timer value before the limit; the handshake timer is 9 bits wide.
  localparam logic [8:0] TO_LAST = 9'(TO_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [8:0]       timer_q, timer_d;
  logic             sw_pend_q, sw_pend_d;
  logic             auto_pend_q, auto_pend_d;
  logic             end_prev_q, end_prev_d;
  logic             sip_q, sip_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             timeout_q, timeout_d;

  logic cnt_active;
  logic cnt_expire;
  logic take;
  logic to_hit;
  logic end_rise;
  logic end_fall;

  assign end_rise = sif.sip_end_i & ~end_prev_q;
  assign end_fall = ~sif.sip_end_i & end_prev_q;

  // Period counter: reloads while idle-disabled or during a frame, fires at 1.
  always_comb begin
    cnt_active = sif.fast_enable & sif.sip_en_i & (sif.sip_period_i != '0);
    cnt_expire = 1'b0;
    cnt_d      = sif.sip_period_i;
    if (cnt_active && !sif.tx_busy_i) begin
      if (cnt_q <= CNT_W'(1)) begin
        cnt_expire = 1'b1;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

  // Handshake sequencing, pending-flag bookkeeping and registered output values.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    take    = 1'b0;
    to_hit  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if ((sw_pend_q | auto_pend_q) & ~sif.tx_busy_i & sif.fast_enable) begin
          take    = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        timer_d = '0;
        state_d = WAIT_END;
      end
      WAIT_END: begin
        if (end_rise) begin
          timer_d = '0;
          state_d = WAIT_IDLE;
        end else if (timer_q == TO_LAST) begin
          to_hit  = 1'b1;
          state_d = IDLE;
        end else begin
          timer_d = timer_q + 9'd1;
        end
      end
      WAIT_IDLE: begin
        if (end_fall) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (timer_q == TO_LAST) begin
          to_hit  = 1'b1;
          state_d = IDLE;
        end else begin
          timer_d = timer_q + 9'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    sw_pend_d   = sif.fast_enable & ((sw_pend_q & ~take) | sif.sw_sip_req_i);
    auto_pend_d = sif.fast_enable & ((auto_pend_q & ~take) | cnt_expire);
    end_prev_d  = sif.sip_end_i;
    sip_d       = (state_d == ISSUE);
    busy_d      = (state_d != IDLE) | done_d | to_hit;
    timeout_d   = to_hit | (timeout_q & ~sif.err_clr_i);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!wb_rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= sif.sip_period_i;
      timer_q     <= '0;
      sw_pend_q   <= 1'b0;
      auto_pend_q <= 1'b0;
      end_prev_q  <= 1'b0;
      sip_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      timer_q     <= timer_d;
      sw_pend_q   <= sw_pend_d;
      auto_pend_q <= auto_pend_d;
      end_prev_q  <= end_prev_d;
      sip_q       <= sip_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      timeout_q   <= timeout_d;
    end
  end

  assign sif.sip_o         = sip_q;
  assign sif.sip_busy_o    = busy_q;
  assign sif.sip_done_o    = done_q;
  assign sif.sip_timeout_o = timeout_q;

endmodule

// File: doc/irda_sip_sched.md
# irda_sip_sched

Scheduler that decides when the IrDA fast-mode (MIR/FIR) Serial Infrared Interaction Pulse is emitted. It merges a programmable periodic timer and single-shot software requests into one request stream. It holds requests off while a frame is being transmitted, sequences the handshake with the SIP pulse generator, and reports completion or timeout to the register file. It sits between the control registers and the SIP generator, driving the generator's request input and monitoring its end-of-SIP output.

## Interface
Parameters:
- CNT_W, 24, width of the period counter and of sip_period_i
- TO_CYCLES, 511, cycle limit for each handshake phase before a timeout is declared (9-bit timer)

Ports:
- clk  in  1  system clock
- wb_rst_n  in  1  synchronous, active-low reset
- fast_enable  in  1  fast IrDA mode active
- sip_en_i  in  1  enable periodic (automatic) SIP
- sip_period_i  in  CNT_W  SIP interval in clk cycles; 0 disables the periodic source
- sw_sip_req_i  in  1  one-cycle software SIP request
- tx_busy_i  in  1  transmitter frame in progress
- sip_end_i  in  1  end-of-SIP window from the generator
- err_clr_i  in  1  clears sip_timeout_o
- sip_o  out  1  request to the generator, one-cycle pulse
- sip_busy_o  out  1  a SIP is outstanding (states ISSUE/WAIT_END/WAIT_IDLE)
- sip_done_o  out  1  one-cycle completion pulse
- sip_timeout_o  out  1  sticky handshake-timeout flag

## Operation
- Reset (wb_rst_n=0 at an edge): state IDLE; sip_o, sip_busy_o, sip_done_o, sip_timeout_o = 0; pending flags cleared; period counter loaded with sip_period_i; handshake timer = 0. This applies mid-handshake as well.
- Period counter, active when fast_enable & sip_en_i & (sip_period_i != 0):
  - Reloads with sip_period_i while tx_busy_i=1 (a frame satisfies the SIP requirement).
  - Otherwise decrements by 1. At 1 it sets auto_pend and reloads on the same edge.
  - When inactive, holds sip_period_i.
  - A new sip_period_i value takes effect at the next reload.
- sw_pend is set by sw_sip_req_i in any state. Requests coalesce: at most one SIP per pending flag.
- If fast_enable=0, sw_pend and auto_pend are cleared and new requests are ignored. An outstanding SIP still runs to completion.
- State machine:
  - IDLE: if (sw_pend | auto_pend) & ~tx_busy_i & fast_enable, go to ISSUE; clear both pend flags.
  - ISSUE: sip_o=1 for this one cycle; clear the timer; go to WAIT_END.
  - WAIT_END: wait for a rising edge of sip_end_i (registered previous value), then clear the timer and go to WAIT_IDLE. If the timer reaches TO_CYCLES first, set sip_timeout_o and go to IDLE.
  - WAIT_IDLE: wait for a falling edge of sip_end_i, then pulse sip_done_o and go to IDLE. Same timeout rule as WAIT_END.
- Requests arriving while sip_busy_o=1 are latched and issued after return to IDLE.
- Simultaneous sw_sip_req_i and counter expiry produce one SIP.
- err_clr_i clears sip_timeout_o. If a timeout occurs on the same edge, set wins.

## Timing
- All outputs are registered.
- sw_sip_req_i sampled at edge k: sw_pend=1 after k; ISSUE (sip_o=1) after k+1, provided tx_busy_i=0 and state was IDLE.
- sip_o is high for exactly 1 cycle, with at least 1 low cycle between pulses. This guarantees a rise for the generator's edge detector.
- Periodic spacing with an idle line: successive sip_o rises are sip_period_i cycles apart, provided the handshake completes within the period. Otherwise the next SIP issues on return to IDLE.
- With the standard generator: sip_end_i rises about 350 cycles after sip_o and falls 71 cycles later. sip_done_o occurs 1 cycle after that fall.
- sip_busy_o is high from the ISSUE cycle through the cycle sip_done_o is asserted or the timeout is set.

## Test plan
- Reset: hold wb_rst_n=0 for 3 cycles with sw_sip_req_i=1 -> all outputs 0, no sip_o after release until a new request.
- Software request with the real generator: fast_enable=1, one sw_sip_req_i pulse -> single sip_o pulse 2 cycles later, sip_busy_o high, sip_done_o about 422 cycles later, sip_timeout_o=0.
- Periodic: sip_period_i=1000, sip_en_i=1, tx_busy_i=0 -> sip_o rises every 1000 cycles; holding tx_busy_i=1 for 1500 cycles suppresses sip_o, and the next one comes 1000 cycles after tx_busy_i falls.
- Coalescing: sw_sip_req_i three times during WAIT_END plus counter expiry -> exactly one further sip_o after sip_done_o.
- Timeout: sip_end_i tied 0 -> sip_timeout_o=1 at TO_CYCLES (511) after ISSUE, no sip_done_o; err_clr_i=1 clears it.
- Mid-operation: fast_enable dropped in WAIT_END with sw_pend set -> current SIP completes, pending discarded; wb_rst_n=0 in WAIT_IDLE -> IDLE, outputs 0 next cycle.
